// File: rtl/cp0_irq_regs_pkg.sv
// rtl/cp0_irq_regs_pkg.sv - CP0 register numbers, field positions and ExcCode constants
package cp0_irq_regs_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam int IE_BIT  = 0;
  localparam int EXL_BIT = 1;
  localparam int BD_BIT  = 31;
  localparam int TI_BIT  = 30;

  localparam logic [31:0] IM7_IM2_BITS = 32'h0000_FC00;
  localparam logic [31:0] IM1_IM0_BITS = 32'h0000_0300;
  localparam logic [31:0] IP7_IP2_BITS = 32'h0000_FC00;
  localparam logic [31:0] IP1_IP0_BITS = 32'h0000_0300;
  localparam logic [31:0] EXCCODE_BITS = 32'h0000_007C;

  localparam logic [31:0] STATUS_WMASK =
    IM7_IM2_BITS | IM1_IM0_BITS | (32'd1 << EXL_BIT) | (32'd1 << IE_BIT);

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a,
    EXC_OV   = 5'h0c
  } exc_code_e;

  function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/cp0_irq_regs_timer.sv
// rtl/cp0_irq_regs_timer.sv - Count/Compare timer with half-rate Count and sticky TI
module cp0_timer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti,
  output logic        ti_next
);

  logic tick;

  // A Compare write acknowledges the interrupt and beats a same-cycle match.
  assign ti_next = compare_we ? 1'b0 : (ti | (count == compare));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick    <= 1'b0;
      count   <= 32'd0;
      compare <= 32'd0;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        tick  <= 1'b0;
      end else begin
        tick <= ~tick;
        if (tick) count <= count + 32'd1;
      end
      if (compare_we) compare <= wdata;
      ti <= ti_next;
    end
  end

endmodule

// File: rtl/cp0_irq_regs.sv
// rtl/cp0_irq_regs.sv - CP0 Status/Cause/EPC/BadVAddr file with timer and HW interrupt sampling
module cp0_irq_regs
  import cp0_irq_regs_pkg::*;
#(
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  ext_int,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic        exc_in_ds,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);

  logic [31:0] status_r, epc_r, badvaddr_r;
  logic [31:0] count, compare;
  logic        bd_r, ti, ti_next;
  logic [5:0]  ip_hw_r;
  logic [1:0]  ip_sw_r;
  logic [4:0]  exccode_r;
  logic        mtc0;

  // Commit-stage exceptions and ERET both squash any MTC0 in the same cycle.
  assign mtc0 = we & ~exc_valid & ~eret;

  cp0_timer u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (mtc0 && (waddr == CP0_COUNT)),
    .compare_we (mtc0 && (waddr == CP0_COMPARE)),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti),
    .ti_next    (ti_next)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_r   <= RESET_STATUS;
      epc_r      <= 32'd0;
      badvaddr_r <= 32'd0;
      bd_r       <= 1'b0;
      ip_hw_r    <= 6'd0;
      ip_sw_r    <= 2'd0;
      exccode_r  <= 5'd0;
    end else begin
      ip_hw_r <= {ext_int[5] | ti_next, ext_int[4:0]};
      if (exc_valid) begin
        if (!status_r[EXL_BIT]) begin
          epc_r <= exc_in_ds ? (exc_pc - 32'd4) : exc_pc;
          bd_r  <= exc_in_ds;
        end
        status_r[EXL_BIT] <= 1'b1;
        exccode_r         <= exc_code;
        if (exc_code == EXC_ADEL || exc_code == EXC_ADES) badvaddr_r <= exc_badvaddr;
      end else if (eret) begin
        status_r[EXL_BIT] <= 1'b0;
      end else if (we) begin
        case (waddr)
          CP0_STATUS: status_r <= masked_write(status_r, wdata, STATUS_WMASK);
          CP0_CAUSE:  ip_sw_r  <= wdata[9:8];
          CP0_EPC:    epc_r    <= wdata;
          default:    ;
        endcase
      end
    end
  end

  assign status_o = status_r;
  assign epc_o    = epc_r;
  assign cause_o  = {bd_r, ti, 14'd0, ip_hw_r, ip_sw_r, 1'b0, exccode_r, 2'b00};

  always_comb begin
    rdata = 32'd0;
    case (raddr)
      CP0_BADVADDR: rdata = badvaddr_r;
      CP0_COUNT:    rdata = count;
      CP0_COMPARE:  rdata = compare;
      CP0_STATUS:   rdata = status_r;
      CP0_CAUSE:    rdata = cause_o;
      CP0_EPC:      rdata = epc_r;
      default:      rdata = 32'd0;
    endcase
  end

endmodule
